scale_seq_arbiter: RTL and testbench



---
 rtl/scale_seq_arbiter_if.sv | 29 ++
 rtl/scale_seq_arbiter.sv | 126 ++++++++++++
 tb/tb_scale_seq_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/scale_seq_arbiter_if.sv
// Request/result bundle for scale_seq_arbiter: requester handshake in, tagged scaled results out.
// slave is the engine's view; master is the requester/consumer side.
interface scale_seq_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int IDW   = 2
);
    localparam int OW = DW + 3;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                out_valid;
    logic [OW-1:0]       out_data;
    logic [IDW-1:0]      out_id;
    logic [1:0]          out_phase;
    logic                out_last;
    logic                busy;

    modport slave (
        input  req_valid, req_data,
        output req_ready, out_valid, out_data, out_id, out_phase, out_last, busy
    );

    modport master (
        output req_valid, req_data,
        input  req_ready, out_valid, out_data, out_id, out_phase, out_last, busy
    );
endinterface

// File: rtl/scale_seq_arbiter.sv
// Round-robin shared scaling engine: each granted byte yields x1, x3, x7, x8 on four
// consecutive cycles, tagged with requester id and phase.
module scale_seq_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    scale_seq_arbiter_if.slave   bus
);
    localparam int OW = DW + 3;

    // Phase to be produced on the next busy edge; PH_X1 doubles as the idle value.
    typedef enum logic [1:0] {
        PH_X1 = 2'd0,
        PH_X3 = 2'd1,
        PH_X7 = 2'd2,
        PH_X8 = 2'd3
    } ph_e;

    logic            r_busy;
    ph_e             r_ph;
    logic [DW-1:0]   r_dreg;
    logic [IDW-1:0]  r_gid;
    logic [IDW-1:0]  r_last;
    logic            r_out_valid;
    logic [OW-1:0]   r_out_data;
    logic [IDW-1:0]  r_out_id;
    logic [1:0]      r_out_phase;

    logic [N_REQ-1:0] w_grant;
    logic [IDW-1:0]   w_gidx;
    logic             w_found;
    logic [DW-1:0]    w_gdata;
    logic [OW-1:0]    w_ext;
    logic [OW-1:0]    w_x3;
    logic [OW-1:0]    w_x7;
    logic [OW-1:0]    w_x8;

    // Search upward from the requester after the last winner, wrapping at N_REQ.
    always_comb begin
        int idx;
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        idx     = 0;
        if (!r_busy && !rst) begin
            for (int k = 1; k <= N_REQ; k++) begin
                idx = (int'(r_last) + k) % N_REQ;
                if (!w_found && bus.req_valid[idx]) begin
                    w_found      = 1'b1;
                    w_grant[idx] = 1'b1;
                    w_gidx       = IDW'(idx);
                end
            end
        end
    end

    assign w_gdata = bus.req_data[w_gidx*DW +: DW];

    // Products at full OW width via shift-add; x7 = x8 - x1 never underflows.
    assign w_ext = OW'(r_dreg);
    assign w_x3  = w_ext + (w_ext << 1);
    assign w_x8  = w_ext << 3;
    assign w_x7  = w_x8 - w_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_ph        <= PH_X1;
            r_dreg      <= '0;
            r_gid       <= '0;
            r_last      <= IDW'(N_REQ - 1);
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_phase <= 2'd0;
        end else if (r_busy) begin
            r_out_valid <= 1'b1;
            r_out_id    <= r_gid;
            case (r_ph)
                PH_X3: begin
                    r_out_data  <= w_x3;
                    r_out_phase <= 2'd1;
                    r_ph        <= PH_X7;
                end
                PH_X7: begin
                    r_out_data  <= w_x7;
                    r_out_phase <= 2'd2;
                    r_ph        <= PH_X8;
                end
                PH_X8: begin
                    r_out_data  <= w_x8;
                    r_out_phase <= 2'd3;
                    r_ph        <= PH_X1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_ph   <= PH_X1;
                    r_busy <= 1'b0;
                end
            endcase
        end else if (w_found) begin
            r_dreg      <= w_gdata;
            r_gid       <= w_gidx;
            r_last      <= w_gidx;
            r_out_data  <= OW'(w_gdata);
            r_out_phase <= 2'd0;
            r_out_id    <= w_gidx;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_ph        <= PH_X3;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_id    = r_out_id;
    assign bus.out_phase = r_out_phase;
    assign bus.out_last  = r_out_valid & (r_out_phase == 2'd3);
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_scale_seq_arbiter.sv
// Directed bench for scale_seq_arbiter: a behavioural arbiter model pushes expected
// results to a queue on each predicted grant; outputs are popped and compared every cycle.
module tb_scale_seq_arbiter;
    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int IDW   = 2;
    localparam int OW    = DW + 3;

    typedef struct packed {
        logic [OW-1:0]  data;
        logic [IDW-1:0] id;
        logic [1:0]     ph;
    } exp_t;

    logic clk = 1'b0;
    logic rst_t = 1'b1;
    logic [N_REQ-1:0] rv = '0;
    logic [N_REQ-1:0] os = '0;
    logic [DW-1:0] d [N_REQ];

    exp_t q[$];
    int   glog[$];
    int   gcnt [N_REQ];
    int   mlast = N_REQ - 1;
    bit   exp_rst = 1'b1;
    int   pend_drop = -1;
    int   vcount = 0;
    int   passed = 0;
    int   total  = 0;

    scale_seq_arbiter_if #(.N_REQ(N_REQ), .DW(DW), .IDW(IDW)) u_if ();

    scale_seq_arbiter #(.N_REQ(N_REQ), .DW(DW), .IDW(IDW)) u_dut (
        .clk (clk),
        .rst (rst_t),
        .bus (u_if)
    );

    assign u_if.req_valid = rv;
    assign u_if.req_data  = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Compare what the last edge produced, then predict the grant for the next edge.
    task automatic check_cycle();
        exp_t e;
        int g;
        int i;
        logic [N_REQ-1:0] eready;
        if (exp_rst) begin
            chk("rst_valid", u_if.out_valid, 0);
            chk("rst_data",  u_if.out_data,  0);
            chk("rst_id",    u_if.out_id,    0);
            chk("rst_phase", u_if.out_phase, 0);
            chk("rst_last",  u_if.out_last,  0);
            exp_rst = 1'b0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            chk("valid", u_if.out_valid, 1);
            chk("data",  u_if.out_data,  e.data);
            chk("id",    u_if.out_id,    e.id);
            chk("phase", u_if.out_phase, e.ph);
            chk("last",  u_if.out_last,  (e.ph == 2'd3));
        end else begin
            chk("idle_valid", u_if.out_valid, 0);
            chk("idle_last",  u_if.out_last,  0);
        end
        if (u_if.out_valid === 1'b1) vcount++;
        chk("busy", u_if.busy, (q.size() != 0));

        g = -1;
        eready = '0;
        if (rst_t) begin
            q.delete();
            mlast   = N_REQ - 1;
            exp_rst = 1'b1;
        end else if (q.size() == 0) begin
            for (int k = 1; k <= N_REQ; k++) begin
                i = (mlast + k) % N_REQ;
                if (g < 0 && rv[i]) g = i;
            end
        end
        if (g >= 0) eready[g] = 1'b1;
        chk("req_ready", u_if.req_ready, eready);
        if (g >= 0) begin
            q.push_back('{data: OW'(int'(d[g])),     id: IDW'(g), ph: 2'd0});
            q.push_back('{data: OW'(int'(d[g]) * 3), id: IDW'(g), ph: 2'd1});
            q.push_back('{data: OW'(int'(d[g]) * 7), id: IDW'(g), ph: 2'd2});
            q.push_back('{data: OW'(int'(d[g]) * 8), id: IDW'(g), ph: 2'd3});
            mlast = g;
            glog.push_back(g);
            gcnt[g]++;
            if (os[g]) pend_drop = g;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        if (pend_drop >= 0) begin
            rv[pend_drop] = 1'b0;
            pend_drop = -1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while ((q.size() != 0 || rv != '0) && n < 64);
        chk("drain_timeout", (n < 64), 1);
        cyc();
    endtask

    initial begin
        int base;
        int c1;
        for (int i = 0; i < N_REQ; i++) begin
            d[i] = '0;
            gcnt[i] = 0;
        end

        // Reset state
        @(posedge clk);
        #1;
        cyc();
        rst_t = 1'b0;
        cyc();

        // Single request from 0: 5, 15, 35, 40; out_data holds after going idle
        d[0] = 8'h05; os = 4'b0001; rv = 4'b0001;
        drain();
        chk("hold_data", u_if.out_data, 40);
        chk("hold_id",   u_if.out_id,   0);
        chk("grant_single", glog[glog.size()-1], 0);

        // Max operand on requester 1: 255, 765, 1785, 2040
        d[1] = 8'hFF; os = 4'b0010; rv = 4'b0010;
        drain();
        chk("grant_max", glog[glog.size()-1], 1);

        // All four continuously after reset: 0,1,2,3,0 with out_valid never dropping
        rst_t = 1'b1;
        cyc();
        rst_t = 1'b0;
        d[0] = 8'd1; d[1] = 8'd2; d[2] = 8'd3; d[3] = 8'd4;
        os = 4'b0000; rv = 4'b1111;
        base = glog.size();
        cyc();
        vcount = 0;
        repeat (20) cyc();
        chk("b2b_valid_cycles", vcount, 20);
        rv = 4'b0000;
        drain();
        chk("rr_order0", glog[base],   0);
        chk("rr_order1", glog[base+1], 1);
        chk("rr_order2", glog[base+2], 2);
        chk("rr_order3", glog[base+3], 3);
        chk("rr_order4", glog[base+4], 0);

        // Fairness after wrap: last winner 2, then 3 and 0 both request -> 3 first
        d[2] = 8'h09; os = 4'b0100; rv = 4'b0100;
        drain();
        d[0] = 8'h11; d[3] = 8'h22; os = 4'b1001; rv = 4'b1001;
        base = glog.size();
        drain();
        chk("wrap_first",  glog[base],   3);
        chk("wrap_second", glog[base+1], 0);

        // Reset during phase 1 of id 2: no phase 2/3, then requester 0 wins first
        d[2] = 8'h0A; os = 4'b0100; rv = 4'b0100;
        cyc();
        cyc();
        rst_t = 1'b1;
        cyc();
        rst_t = 1'b0;
        d[0] = 8'h03; os = 4'b0101; rv = 4'b0101;
        base = glog.size();
        drain();
        chk("post_rst_first",  glog[base],   0);
        chk("post_rst_second", glog[base+1], 2);

        // Requester 1 pulses only while busy: never granted
        c1 = gcnt[1];
        d[3] = 8'h40; os = 4'b1000; rv = 4'b1000;
        cyc();
        cyc();
        rv[1] = 1'b1;
        cyc();
        rv[1] = 1'b0;
        drain();
        chk("withdrawn_no_grant", gcnt[1], c1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
